// File: rtl/memory_arbiter_if.sv
// Request/response bundle between the fetch path, the memory stage and the
// unified RAM port, as seen by memory_arbiter (slave) and its environment.
interface memory_arbiter_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic              iren;
    logic [ADDR_W-1:0] iaddr;
    logic              dren;
    logic              dwen;
    logic [ADDR_W-1:0] daddr;
    logic [WORD_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [WORD_W-1:0] iload;
    logic [WORD_W-1:0] dload;
    logic              ram_ren;
    logic              ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [WORD_W-1:0] ram_wdata;
    logic [WORD_W-1:0] ram_rdata;
    logic              ram_ready;

    modport slave (
        input  iren, iaddr, dren, dwen, daddr, dstore,
        input  ram_rdata, ram_ready,
        output ihit, dhit, iload, dload,
        output ram_ren, ram_wen, ram_addr, ram_wdata
    );

    modport master (
        output iren, iaddr, dren, dwen, daddr, dstore,
        output ram_rdata, ram_ready,
        input  ihit, dhit, iload, dload,
        input  ram_ren, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter for the single unified RAM port, data has priority.
// Define MEM_ARB_FAIR_EN to force a fetch grant after STARVE_LIMIT data grants.
module memory_arbiter #(
    parameter int WORD_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input logic             CLK,
    input logic             nRST,
    memory_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic              drop_q, drop_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              ihit_q, ihit_d;
    logic              dhit_q, dhit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] iload_q, iload_d;
    logic [WORD_W-1:0] dload_q, dload_d;

    logic dreq;
    logic force_i;
    logic grant_d;
    logic own;

    assign dreq    = bus.dren | bus.dwen;
    assign grant_d = dreq & ~force_i;

`ifdef MEM_ARB_FAIR_EN
    logic [3:0] cnt_q, cnt_d;

    assign force_i = bus.iren && (cnt_q == 4'(STARVE_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (grant_d) begin
                if (bus.iren) cnt_d = cnt_q + 4'd1;
            end else if (bus.iren) begin
                cnt_d = 4'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end
`else
    logic unused_limit;

    assign force_i      = 1'b0;
    assign unused_limit = (STARVE_LIMIT > 0);
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        drop_d  = drop_q;
        ren_d   = ren_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        iload_d = iload_q;
        dload_d = dload_q;
        ihit_d  = 1'b0;
        dhit_d  = 1'b0;
        own     = 1'b0;
        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_d) begin
                    state_d = DBUSY;
                    addr_d  = bus.daddr;
                    wdata_d = bus.dstore;
                    we_d    = bus.dwen;
                    ren_d   = ~bus.dwen;
                    wen_d   = bus.dwen;
                end else if (bus.iren) begin
                    state_d = IBUSY;
                    addr_d  = bus.iaddr;
                    we_d    = 1'b0;
                    ren_d   = 1'b1;
                    wen_d   = 1'b0;
                end
            end
            IBUSY, DBUSY: begin
                // A flushed requester still lets the RAM access finish.
                own    = (state_q == IBUSY) ? bus.iren : dreq;
                drop_d = drop_q | ~own;
                if (bus.ram_ready) begin
                    state_d = RESP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    if (!drop_d) begin
                        if (state_q == IBUSY) begin
                            ihit_d  = 1'b1;
                            iload_d = bus.ram_rdata;
                        end else begin
                            dhit_d = 1'b1;
                            if (!we_q) dload_d = bus.ram_rdata;
                        end
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            drop_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            ihit_q  <= 1'b0;
            dhit_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            drop_q  <= drop_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            ihit_q  <= ihit_d;
            dhit_q  <= dhit_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end
    end

    assign bus.ihit      = ihit_q;
    assign bus.dhit      = dhit_q;
    assign bus.iload     = iload_q;
    assign bus.dload     = dload_q;
    assign bus.ram_ren   = ren_q;
    assign bus.ram_wen   = wen_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-level model.
// Fairness expectations follow MEM_ARB_FAIR_EN when it is defined.
module tb_memory_arbiter;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;
    localparam int LIMIT  = 2;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;

    memory_arbiter_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

    memory_arbiter #(
        .WORD_W       (WORD_W),
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int          n_chk   = 0;
    int          n_fail  = 0;
    int          m_cnt   = 0;
    logic [31:0] m_iload = '0;
    logic [31:0] m_dload = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ren"},   32'(bus.ram_ren),  32'd0);
        check({tag, "_wen"},   32'(bus.ram_wen),  32'd0);
        check({tag, "_ihit"},  32'(bus.ihit),     32'd0);
        check({tag, "_dhit"},  32'(bus.dhit),     32'd0);
        check({tag, "_iload"}, bus.iload,         32'd0);
        check({tag, "_dload"}, bus.dload,         32'd0);
        check({tag, "_addr"},  bus.ram_addr,      32'd0);
        check({tag, "_wdata"}, bus.ram_wdata,     32'd0);
    endtask

    task automatic drop_req(input bit is_d);
        if (is_d) begin
            bus.dren = 1'b0;
            bus.dwen = 1'b0;
        end else begin
            bus.iren = 1'b0;
        end
    endtask

    // Entered at the negedge of the grant cycle, leaves at the next IDLE.
    task automatic serve(input bit is_d, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits,
                         input int drop_at);
        bit kept;
        check("grant_ren", 32'(bus.ram_ren), 32'd0);
        check("grant_wen", 32'(bus.ram_wen), 32'd0);
        if (is_d) begin
            if (bus.iren) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        @(negedge CLK);
        for (int k = 0; k <= waits; k++) begin
            check("busy_ren",   32'(bus.ram_ren), 32'(!we));
            check("busy_wen",   32'(bus.ram_wen), 32'(we));
            check("busy_addr",  bus.ram_addr, addr);
            if (we) check("busy_wdata", bus.ram_wdata, wdata);
            check("busy_hit",   32'({bus.ihit, bus.dhit}), 32'd0);
            check("busy_iload", bus.iload, m_iload);
            check("busy_dload", bus.dload, m_dload);
            if (k == drop_at) drop_req(is_d);
            bus.ram_ready = (k == waits);
            bus.ram_rdata = (k == waits) ? rdata : 32'($urandom);
            @(negedge CLK);
        end
        bus.ram_ready = 1'b0;
        kept = (drop_at < 0);
        if (kept && !we) begin
            if (is_d) m_dload = rdata;
            else      m_iload = rdata;
        end
        check("resp_ihit",  32'(bus.ihit), 32'(kept && !is_d));
        check("resp_dhit",  32'(bus.dhit), 32'(kept && is_d));
        check("resp_iload", bus.iload, m_iload);
        check("resp_dload", bus.dload, m_dload);
        check("resp_strb",  32'({bus.ram_ren, bus.ram_wen}), 32'd0);
        drop_req(is_d);
        @(negedge CLK);
        check("post_hit", 32'({bus.ihit, bus.dhit}), 32'd0);
    endtask

    task automatic serve_rand(input bit is_d, input bit we,
                              input logic [31:0] addr,
                              input logic [31:0] wdata);
        int waits;
        int drop_at;
        waits   = int'($urandom_range(0, 3));
        drop_at = ($urandom_range(0, 3) == 0) ?
                  int'($urandom_range(0, waits)) : -1;
        serve(is_d, we, addr, wdata, 32'($urandom), waits, drop_at);
    endtask

    task automatic rand_round();
        bit          ir, dr, dw, dq, force_i;
        logic [31:0] ia, da, ds;
        ir = 1'($urandom_range(0, 1));
        dr = 1'($urandom_range(0, 1));
        dw = 1'($urandom_range(0, 1));
        ia = $urandom;
        da = $urandom;
        ds = $urandom;
        dq = dr | dw;
        bus.iren = ir;  bus.iaddr = ia;
        bus.dren = dr;  bus.dwen  = dw;
        bus.daddr = da; bus.dstore = ds;
        if (!ir && !dq) begin
            @(negedge CLK);
            check("idle_strb", 32'({bus.ram_ren, bus.ram_wen}), 32'd0);
            check("idle_hit",  32'({bus.ihit, bus.dhit}), 32'd0);
            return;
        end
        force_i = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        force_i = ir && (m_cnt == LIMIT);
`endif
        if (dq && !force_i) begin
            serve_rand(1'b1, dw, da, ds);
            if (ir) serve_rand(1'b0, 1'b0, ia, '0);
        end else begin
            serve_rand(1'b0, 1'b0, ia, '0);
            if (dq) serve_rand(1'b1, dw, da, ds);
        end
    endtask

    initial begin
        bit is_i;
        bus.iren = 0; bus.iaddr = '0; bus.dren = 0; bus.dwen = 0;
        bus.daddr = '0; bus.dstore = '0;
        bus.ram_rdata = '0; bus.ram_ready = 0;

        repeat (3) @(negedge CLK);
        check_zero("rst");
        nRST = 1'b1;
        @(negedge CLK);

        // single zero-wait fetch
        bus.iren = 1; bus.iaddr = 32'h100;
        serve(1'b0, 1'b0, 32'h100, '0, 32'hDEADBEEF, 0, -1);
        check("fetch_iload", bus.iload, 32'hDEADBEEF);

        // simultaneous fetch and write: data first
        bus.iren = 1; bus.iaddr = 32'h104;
        bus.dwen = 1; bus.daddr = 32'h200; bus.dstore = 32'h12345678;
        serve(1'b1, 1'b1, 32'h200, 32'h12345678, 32'h0, 0, -1);
        serve(1'b0, 1'b0, 32'h104, '0, 32'hCAFE0001, 0, -1);

        // data read with three wait states
        bus.dren = 1; bus.daddr = 32'h300;
        serve(1'b1, 1'b0, 32'h300, '0, 32'hA5A55A5A, 3, -1);

        // fetch flushed during IBUSY
        bus.iren = 1; bus.iaddr = 32'h400;
        serve(1'b0, 1'b0, 32'h400, '0, 32'h0BADF00D, 2, 1);
        check("flush_iload", bus.iload, 32'hCAFE0001);

        // asynchronous reset in DBUSY
        bus.dren = 1; bus.daddr = 32'h500;
        @(negedge CLK);
        check("pre_rst_ren", 32'(bus.ram_ren), 32'd1);
        #2 nRST = 1'b0;
        #1 check_zero("async_rst");
        bus.dren = 0;
        m_iload = '0; m_dload = '0; m_cnt = 0;
        @(negedge CLK);
        check_zero("held_rst");
        nRST = 1'b1;
        @(negedge CLK);
        bus.iren = 1; bus.iaddr = 32'h600;
        serve(1'b0, 1'b0, 32'h600, '0, 32'h600D600D, 1, -1);

        // both held continuously: order from the starvation rule
        bus.iaddr = 32'h700; bus.daddr = 32'h800;
        for (int g = 0; g < 6; g++) begin
            bus.iren = 1; bus.dren = 1;
            is_i = 1'b0;
`ifdef MEM_ARB_FAIR_EN
            is_i = (m_cnt == LIMIT);
`endif
            serve(!is_i, 1'b0, is_i ? 32'h700 : 32'h800, '0,
                  32'($urandom), 0, -1);
        end
        bus.iren = 0; bus.dren = 0;
        @(negedge CLK);

        for (int r = 0; r < 200; r++) rand_round();

        bus.iren = 0; bus.dren = 0; bus.dwen = 0;
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
